// File: rtl/alu_serial.sv
// alu_serial: bit-serial 32-bit ALU, one bit per cycle LSB first, fixed 34-cycle operation.
// Define ALU_SERIAL_SEQ_EN to add the SEQ (set-if-equal, code 1111) operation.
module alu_serial (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic [3:0]  ALU_control_i,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        cout_o,
   output logic        overflow_o,
   output logic        busy_o,
   output logic        done_o
);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   typedef struct packed {
      logic       valid;
      logic       a_inv;
      logic       b_inv;
      logic [1:0] op;
   } dec_t;

   function automatic dec_t decode(input logic [3:0] c);
      case (c)
         4'b0000: decode = '{1'b1, 1'b0, 1'b0, 2'd0};
         4'b0001: decode = '{1'b1, 1'b0, 1'b0, 2'd1};
         4'b0010: decode = '{1'b1, 1'b0, 1'b0, 2'd2};
         4'b0110: decode = '{1'b1, 1'b0, 1'b1, 2'd2};
         4'b0111: decode = '{1'b1, 1'b0, 1'b1, 2'd3};
         4'b1100: decode = '{1'b1, 1'b1, 1'b1, 2'd0};
         4'b1101: decode = '{1'b1, 1'b1, 1'b1, 2'd1};
`ifdef ALU_SERIAL_SEQ_EN
         4'b1111: decode = '{1'b1, 1'b0, 1'b1, 2'd2};
`endif
         default: decode = '0;
      endcase
   endfunction

   function automatic logic cin_of(input logic [3:0] c);
`ifdef ALU_SERIAL_SEQ_EN
      cin_of = c == 4'b0110 || c == 4'b0111 || c == 4'b1111;
`else
      cin_of = c == 4'b0110 || c == 4'b0111;
`endif
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic        zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
   dec_t        dec;
   logic        a, b, sum, bit_r, carry_n, ovf, less, is_slt, is_arith;
   logic [31:0] final_r;
`ifdef ALU_SERIAL_SEQ_EN
   logic        eq_q, eq_d;
`endif

   always_comb begin
      dec      = decode(ctrl_q);
      a        = dec.a_inv ^ a_q[0];
      b        = dec.b_inv ^ b_q[0];
      sum      = a ^ b ^ carry_q;
      bit_r    = dec.op == 2'd0 ? a & b : dec.op == 2'd1 ? a | b : sum;
      carry_n  = dec.op[1] & ((carry_q & (a | b)) | (a & b));
      ovf      = carry_q ^ carry_n;
      less     = sum ^ ovf;
      is_slt   = ctrl_q == 4'b0111;
      is_arith = ctrl_q == 4'b0010 || ctrl_q == 4'b0110;
`ifdef ALU_SERIAL_SEQ_EN
      final_r  = !dec.valid ? 32'd0 : is_slt ? {31'd0, less} :
                 ctrl_q == 4'b1111 ? {31'd0, eq_q & ~sum} : {bit_r, acc_q[31:1]};
      eq_d     = eq_q;
`else
      final_r  = !dec.valid ? 32'd0 : is_slt ? {31'd0, less} : {bit_r, acc_q[31:1]};
`endif
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      ctrl_d   = ctrl_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = RUN;
            a_d     = src1_i;
            b_d     = src2_i;
            ctrl_d  = ALU_control_i;
            carry_d = cin_of(ALU_control_i);
            cnt_d   = 5'd0;
`ifdef ALU_SERIAL_SEQ_EN
            eq_d    = 1'b1;
`endif
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            acc_d   = {bit_r, acc_q[31:1]};
            carry_d = carry_n;
            cnt_d   = cnt_q + 5'd1;
`ifdef ALU_SERIAL_SEQ_EN
            eq_d    = eq_q & ~sum;
`endif
            // bit 31 closes the operation: capture the visible results
            if (cnt_q == 5'd31) begin
               state_d  = FIN;
               result_d = final_r;
               zero_d   = dec.valid & (final_r == 32'd0);
               cout_d   = carry_n;
               ovf_d    = is_arith & ovf;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         ctrl_q   <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ALU_SERIAL_SEQ_EN
         eq_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
`ifdef ALU_SERIAL_SEQ_EN
         eq_q     <= eq_d;
`endif
      end
   end

   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;
   assign busy_o     = state_q != IDLE;
   assign done_o     = state_q == FIN;
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed vectors for alu_serial with hand-computed expectations.
module tb_alu_serial;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] src1 = '0, src2 = '0, result;
   logic [3:0]  ctrl = '0;
   logic        zero, cout, ovf, busy, done;
   int          tests = 0, fails = 0;

   alu_serial dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
      .ALU_control_i(ctrl), .result_o(result), .zero_o(zero), .cout_o(cout),
      .overflow_o(ovf), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [3:0] code, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                      input logic exp_c, input logic exp_o, input bit pulse);
      int lat;
      src1 = a; src2 = b; ctrl = code; start = 1'b1;
      tick();
      start = 1'b0; src1 = ~a; src2 = ~b; ctrl = 4'b0011;
      chk({tag, "_busy"}, 32'(busy), 1);
      lat = 0;
      while (!done && lat < 40) begin
         start = pulse && lat == 4;
         tick();
         lat++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, lat, 32);
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_zero"}, 32'(zero), 32'(exp_z));
      chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
      chk({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
      start = pulse;
      tick();
      start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done), 0);
      chk({tag, "_idle"}, 32'(busy), 0);
      chk({tag, "_hold"}, result, exp_r);
   endtask

   initial begin
      int n;
      tick();
      tick();
      chk("rst_result", result, 0);
      chk("rst_zero", 32'(zero), 1);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      start = 1'b1; src1 = 32'd1; src2 = 32'd1; ctrl = 4'b0010;
      tick();
      chk("rst_over_start", 32'(busy), 0);
      rst = 1'b0; start = 1'b0;
      tick();

      run("and",  4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 0, 0);
      run("or",   4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 0, 0);
      run("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0);
      run("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0);
      run("sub_eq", 4'b0110, 32'd5, 32'd5, 32'd0, 1, 1, 0, 1);
      n = 0;
      repeat (40) begin
         tick();
         n += int'(done);
      end
      chk("repulse_no_done", n, 0);
      run("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'd1, 0, 1, 0, 0);
      run("slt_min", 4'b0111, 32'h80000000, 32'h00000001, 32'd1, 0, 1, 0, 0);
      run("slt_gt",  4'b0111, 32'd3, 32'd2, 32'd0, 1, 1, 0, 0);
      run("nor",  4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0);

      src1 = 32'd7; src2 = 32'd9; ctrl = 4'b0010; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_result", result, 0);
      chk("abort_zero", 32'(zero), 1);
      n = 0;
      repeat (40) begin
         tick();
         n += int'(done);
      end
      chk("abort_no_done", n, 0);

      run("nand", 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 0);
      run("bad_code", 4'b0011, 32'd5, 32'd3, 32'd0, 0, 0, 0, 0);
`ifdef ALU_SERIAL_SEQ_EN
      run("seq_eq", 4'b1111, 32'h1234, 32'h1234, 32'd1, 0, 1, 0, 0);
      run("seq_ne", 4'b1111, 32'h1234, 32'h1235, 32'd0, 1, 0, 0, 0);
`else
      run("seq_eq", 4'b1111, 32'h1234, 32'h1234, 32'd0, 0, 0, 0, 0);
      run("seq_ne", 4'b1111, 32'h1234, 32'h1235, 32'd0, 0, 0, 0, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
